// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
//  Module   : mux4_rr_arbiter_pkg
//  Brief    : Shared state encodings and sizing constants for the mux4 arbiter
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int c_num_req = 4;
    localparam int c_sel_w   = 2;

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_pick4.sv
// ============================================================================
//  Module   : rr_pick4
//  Brief    : Combinational rotating-priority picker over four request lines
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [c_num_req-1:0] req,
    input  logic [c_sel_w-1:0]   ptr,
    output logic                 any,
    output logic [c_sel_w-1:0]   win_idx,
    output logic [c_num_req-1:0] win_onehot
);

    logic [c_sel_w-1:0] w_idx;

    // Walk from the furthest offset back to ptr so the nearest set bit wins last.
    always_comb begin
        any     = |req;
        win_idx = '0;
        w_idx   = '0;
        for (int i = c_num_req - 1; i >= 0; i--) begin
            w_idx = ptr + c_sel_w'(i);
            if (req[w_idx]) begin
                win_idx = w_idx;
            end
        end
        win_onehot = any ? (c_num_req'(1) << win_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  Module   : mux4_rr_arbiter
//  Brief    : Round-robin arbiter driving the select of a shared 4:1 mux,
//             with bounded ownership and a forced-release timeout pulse
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [c_num_req-1:0] req,
    output logic [c_num_req-1:0] grant,
    output logic [c_sel_w-1:0]   sel,
    output logic                 busy,
    output logic                 timeout
);

    state_t                 r_state;
    logic [c_sel_w-1:0]     r_ptr;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [c_num_req-1:0]   r_grant;
    logic [c_sel_w-1:0]     r_sel;
    logic                   r_timeout;

    state_t                 w_state_next;
    logic [c_sel_w-1:0]     w_ptr_next;
    logic [CNT_W-1:0]       w_hold_next;
    logic [c_num_req-1:0]   w_grant_next;
    logic [c_sel_w-1:0]     w_sel_next;
    logic                   w_timeout_next;
    logic                   w_take_new;

    logic                   w_any;
    logic [c_sel_w-1:0]     w_win_idx;
    logic [c_num_req-1:0]   w_win_onehot;
    logic                   w_owner_req;
    logic                   w_limit_hit;

    rr_pick4 u_pick (
        .req        (req),
        .ptr        (r_ptr),
        .any        (w_any),
        .win_idx    (w_win_idx),
        .win_onehot (w_win_onehot)
    );

    // While owning, sel always names the owner, so it doubles as the owner index.
    assign w_owner_req = req[r_sel];
    assign w_limit_hit = (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(MAX_HOLD));

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold_cnt;
        w_grant_next   = r_grant;
        w_sel_next     = r_sel;
        w_timeout_next = 1'b0;
        w_take_new     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_take_new = w_any;
            end
            ST_OWN: begin
                if (w_owner_req && !w_limit_hit) begin
                    if (r_hold_cnt != {CNT_W{1'b1}}) begin
                        w_hold_next = r_hold_cnt + CNT_W'(1);
                    end
                end else begin
                    // ptr already points past the owner, so a timed-out owner ranks last.
                    w_timeout_next = w_owner_req;
                    if (w_any) begin
                        w_take_new = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_grant_next = '0;
                        w_hold_next  = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase

        if (w_take_new) begin
            w_state_next = ST_OWN;
            w_grant_next = w_win_onehot;
            w_sel_next   = w_win_idx;
            w_ptr_next   = w_win_idx + c_sel_w'(1);
            w_hold_next  = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_sel      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_next;
            r_grant    <= w_grant_next;
            r_sel      <= w_sel_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = |r_grant;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  Module   : tb_mux4_rr_arbiter
//  Brief    : Self-checking bench for mux4_rr_arbiter (model + directed vectors)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner index (-1 when idle), rotating start point, hold length.
    typedef struct packed {
        int   owner;
        int   ptr;
        int   hold;
        int   sel;
        logic to;
    } mstate_t;

    mstate_t m = '{owner: -1, ptr: 0, hold: 0, sel: 0, to: 1'b0};

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r);
        mstate_t n = s;
        int w;
        n.to = 1'b0;
        if (s.owner >= 0 && r[s.owner] && (MAX_HOLD == 0 || s.hold < MAX_HOLD)) begin
            n.hold = s.hold + 1;
            return n;
        end
        if (s.owner >= 0 && r[s.owner]) n.to = 1'b1;
        w = pick(r, s.ptr);
        if (w < 0) begin
            n.owner = -1;
            n.hold  = 0;
        end else begin
            n.owner = w;
            n.sel   = w;
            n.ptr   = (w + 1) % 4;
            n.hold  = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{owner: -1, ptr: 0, hold: 0, sel: 0, to: 1'b0};
        else          m <= model_next(m, req);
    end

    function automatic logic [3:0] model_grant(input mstate_t s);
        return (s.owner < 0) ? 4'b0000 : (4'b0001 << s.owner);
    endfunction

    always @(negedge clk) begin
        check("mdl_grant",   32'(grant),   32'(model_grant(m)));
        check("mdl_sel",     32'(sel),     32'(m.sel));
        check("mdl_busy",    32'(busy),    32'(m.owner >= 0));
        check("mdl_timeout", 32'(timeout), 32'(m.to));
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        int to_cnt;

        // Reset holds everything off even with all requests high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel",   32'(sel),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        reset_n = 1'b1;
        step(4'b0010);
        check("first_grant", 32'(grant), 32'h2);
        check("first_sel",   32'(sel),   32'h1);

        // All requesting: each owner keeps 8 cycles, timeout on each handoff.
        pulse_reset();
        to_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            step(4'b1111);
            check("rr_grant", 32'(grant), 32'(4'b0001 << (((n - 1) / 8) % 4)));
            check("rr_timeout", 32'(timeout), 32'(n > 1 && ((n - 1) % 8) == 0));
            if (timeout) to_cnt++;
        end
        check("rr_timeout_cnt", 32'(to_cnt), 32'd4);

        // Owner drops while another is pending: back-to-back handoff.
        pulse_reset();
        step(4'b0100);
        check("b2b_own2", 32'(grant), 32'h4);
        step(4'b0001);
        check("b2b_grant", 32'(grant), 32'h1);
        check("b2b_sel",   32'(sel),   32'h0);
        check("b2b_busy",  32'(busy),  32'h1);

        // Lone requester: re-granted across forced releases.
        pulse_reset();
        to_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            step(4'b0100);
            check("solo_grant",   32'(grant),   32'h4);
            check("solo_timeout", 32'(timeout), 32'(n == 9 || n == 17));
            if (timeout) to_cnt++;
        end
        check("solo_timeout_cnt", 32'(to_cnt), 32'd2);

        // Go idle: sel keeps the last owner.
        pulse_reset();
        step(4'b1000);
        check("idle_own3", 32'(grant), 32'h8);
        check("idle_sel3", 32'(sel),   32'h3);
        step(4'b0000);
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_busy",  32'(busy),  32'h0);
        check("idle_sel",   32'(sel),   32'h3);
        step(4'b0000);
        check("idle_sel_hold", 32'(sel), 32'h3);
        step(4'b0001);
        check("idle_regrant", 32'(grant), 32'h1);
        check("idle_resel",   32'(sel),   32'h0);

        // Asynchronous reset mid-grant; ptr would be 1 without the reset.
        step(4'b1111);
        check("arst_pre", 32'(grant), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_busy",  32'(busy),  32'h0);
        check("arst_sel",   32'(sel),   32'h0);
        #1;
        reset_n = 1'b1;
        step(4'b1111);
        check("arst_restart", 32'(grant), 32'h1);
        step(4'b0000);
        step(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
